// File: rtl/force_release_ctrl.sv
// Force/release override responder: selected bits of a registered pass-through
// path carry a stored value, either permanently or for a timed hold window.
module force_release_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_mask,
    input  logic [WIDTH-1:0]  cmd_value,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [WIDTH-1:0]  force_mask,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOP         = 2'b00;
    localparam logic [1:0] OP_FORCE       = 2'b01;
    localparam logic [1:0] OP_RELEASE     = 2'b10;
    localparam logic [1:0] OP_FORCE_TIMED = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   force_val;
    logic [WIDTH-1:0]   timed_mask;
    logic [HOLD_W-1:0]  counter;

    function automatic logic [WIDTH-1:0] apply_override(
        input logic [WIDTH-1:0] src,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] val
    );
        return (src & ~mask) | (val & mask);
    endfunction

    assign cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            force_mask <= '0;
            force_val  <= '0;
            timed_mask <= '0;
            counter    <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
        end else begin
            // Output stage: uses pre-edge mask/value, so commands show up one edge later
            data_out <= apply_override(data_in, force_mask, force_val);

            if (abort) begin
                force_mask <= '0;
                timed_mask <= '0;
                counter    <= '0;
                state      <= IDLE;
                busy       <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        counter <= counter - HOLD_W'(1);
                        // Timed release wins over any earlier permanent force on the same bits
                        if (counter == HOLD_W'(1)) begin
                            force_mask <= force_mask & ~timed_mask;
                            timed_mask <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                    end
                    default: begin
                        if (cmd_valid) begin
                            case (cmd_op)
                                OP_FORCE: begin
                                    force_mask <= force_mask | cmd_mask;
                                    force_val  <= apply_override(force_val, cmd_mask, cmd_value);
                                end
                                OP_RELEASE: begin
                                    force_mask <= force_mask & ~cmd_mask;
                                end
                                OP_FORCE_TIMED: begin
                                    force_mask <= force_mask | cmd_mask;
                                    force_val  <= apply_override(force_val, cmd_mask, cmd_value);
                                    if (cmd_hold != '0) begin
                                        timed_mask <= cmd_mask;
                                        counter    <= cmd_hold;
                                        state      <= HOLD;
                                        busy       <= 1'b1;
                                    end
                                end
                                OP_NOP: begin
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
